// File: rtl/soc_clk_divider.sv
// soc_clk_divider: divides the board clock CLK by 2**SLOW and generates the core reset.
// resetn asserts asynchronously and releases only on the CLK edge where clk falls.
module soc_clk_divider #(
   parameter int unsigned SLOW     = 2,
   parameter int unsigned RST_HOLD = 2
) (
   input  logic CLK,
   input  logic RESET,
   output logic clk,
   output logic resetn
);

   localparam int unsigned      CNT_W         = (SLOW < 1) ? 1 : SLOW;
   localparam logic [CNT_W-1:0] CNT_RISE_PREV = CNT_W'((64'd1 << (CNT_W - 1)) - 64'd1);
   localparam logic [7:0]       HOLD_INIT     = 8'(RST_HOLD);

   if (SLOW < 1) begin : g_bad_slow
      $error("soc_clk_divider: SLOW must be >= 1");
   end
   if (RST_HOLD > 255) begin : g_bad_hold
      $error("soc_clk_divider: RST_HOLD must be in 0..255");
   end

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             s1_q, s1_d;
   logic             s2_q, s2_d;
   logic [7:0]       hold_q, hold_d;
   logic             resetn_q, resetn_d;
   logic             rise_edge;
   logic             wrap_edge;

   always_comb begin
      cnt_d     = cnt_q + CNT_W'(1);
      rise_edge = (cnt_q == CNT_RISE_PREV);
      wrap_edge = (cnt_q == '1);
      s1_d      = 1'b1;
      s2_d      = s1_q;
      hold_d    = hold_q;
      resetn_d  = resetn_q;
      // hold_q counts the qualified clk rising edges still owed before release
      if (s2_q && rise_edge && (hold_q != 8'd0)) begin
         hold_d = hold_q - 8'd1;
      end
      if (s2_q && wrap_edge && (hold_q == 8'd0)) begin
         resetn_d = 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         cnt_q    <= '0;
         s1_q     <= 1'b0;
         s2_q     <= 1'b0;
         hold_q   <= HOLD_INIT;
         resetn_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         s1_q     <= s1_d;
         s2_q     <= s2_d;
         hold_q   <= hold_d;
         resetn_q <= resetn_d;
      end
   end

   assign clk    = cnt_q[CNT_W-1];
   assign resetn = resetn_q;

endmodule

// File: tb/tb_soc_clk_divider.sv
// Bench for soc_clk_divider: three parameterizations share CLK/RESET and are scored per edge
// against an edge-numbered model (E0 = first CLK posedge with RESET high).
module tb_soc_clk_divider;

   logic       CLK = 1'b0;
   logic       RESET = 1'b0;
   logic [2:0] clk_v;
   logic [2:0] rstn_v;

   int total = 0;
   int bad   = 0;

   // a: SLOW=2 RST_HOLD=2, b: SLOW=2 RST_HOLD=0, c: SLOW=1 RST_HOLD=2
   soc_clk_divider #(.SLOW(2), .RST_HOLD(2)) u_a (.CLK(CLK), .RESET(RESET), .clk(clk_v[0]), .resetn(rstn_v[0]));
   soc_clk_divider #(.SLOW(2), .RST_HOLD(0)) u_b (.CLK(CLK), .RESET(RESET), .clk(clk_v[1]), .resetn(rstn_v[1]));
   soc_clk_divider #(.SLOW(1), .RST_HOLD(2)) u_c (.CLK(CLK), .RESET(RESET), .clk(clk_v[2]), .resetn(rstn_v[2]));

   always #5 CLK = ~CLK;

   typedef struct {
      int         k;
      logic [2:0] eclk;
      logic [2:0] erst;
   } exp_t;

   exp_t sb[$];

   int slow_t[3] = '{2, 2, 1};
   // release edges worked out by hand from the edge numbering: E11, E3, E5
   int rel_t[3]  = '{11, 3, 5};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic exp_clk(input int s, input int k);
      int p;
      p = 1 << s;
      return (((k + 1) % p) >= (p / 2)) ? 1'b1 : 1'b0;
   endfunction

   task automatic check_all_low(input string tag);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("%s_clk%0d", tag, i), 32'(clk_v[i]), 32'd0);
         chk($sformatf("%s_rstn%0d", tag, i), 32'(rstn_v[i]), 32'd0);
      end
   endtask

   // drives n edges starting at E0; expected values are queued before each edge and
   // popped after it, with a release-on-clk-fall check whenever resetn rises
   task automatic run_edges(input int n);
      exp_t       e;
      logic [2:0] prev_clk;
      logic [2:0] prev_rst;
      prev_clk = clk_v;
      prev_rst = rstn_v;
      for (int k = 0; k < n; k++) begin
         e.k = k;
         for (int i = 0; i < 3; i++) begin
            e.eclk[i] = exp_clk(slow_t[i], k);
            e.erst[i] = (k >= rel_t[i]) ? 1'b1 : 1'b0;
         end
         sb.push_back(e);
         @(posedge CLK);
         #1;
         e = sb.pop_front();
         for (int i = 0; i < 3; i++) begin
            chk($sformatf("clk%0d_E%0d", i, e.k), 32'(clk_v[i]), 32'(e.eclk[i]));
            chk($sformatf("rstn%0d_E%0d", i, e.k), 32'(rstn_v[i]), 32'(e.erst[i]));
            if (!prev_rst[i] && rstn_v[i]) begin
               chk($sformatf("rel_on_fall%0d_E%0d", i, e.k), 32'({prev_clk[i], clk_v[i]}), 32'b10);
            end
         end
         prev_clk = clk_v;
         prev_rst = rstn_v;
      end
   endtask

   initial begin
      #2;
      check_all_low("por");

      repeat (20) begin
         @(negedge CLK);
         check_all_low("held");
      end

      RESET = 1'b1;
      run_edges(40);

      @(posedge CLK);
      #2;
      RESET = 1'b0;
      #2;
      check_all_low("glitch");
      #3;
      RESET = 1'b1;
      run_edges(1100);

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
